// File: rtl/ysyx_25060170_wb_arb.sv
// Writeback arbiter: round-robin (or fixed, LSU-first) selection of EXU/LSU results into a
// one-entry output slot feeding the GPR write port. Define YSYX_25060170_WB_ARB_FIXED_PRIO_EN for fixed priority.
module ysyx_25060170_wb_arb #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_rd,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_rd,
  input  logic [DW-1:0] req1_data,
  output logic          gpr_wen,
  output logic [AW-1:0] gpr_waddr,
  output logic [DW-1:0] gpr_wdata,
  input  logic          gpr_ready,
  output logic          busy
);

  logic          slot_v_q, slot_v_d;
  logic [AW-1:0] slot_rd_q, slot_rd_d;
  logic [DW-1:0] slot_data_q, slot_data_d;
  logic          slot_free, win1, grant0, grant1, xfer;
  logic [AW-1:0] xfer_rd;
  logic [DW-1:0] xfer_data;

`ifdef YSYX_25060170_WB_ARB_FIXED_PRIO_EN
  always_comb win1 = req1_valid;
`else
  logic prio_q, prio_d;

  // prio_q == 1 prefers req1; after a grant the other requester is preferred
  always_comb begin
    win1   = req1_valid & (~req0_valid | prio_q);
    prio_d = xfer ? grant0 : prio_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end
`endif

  always_comb begin
    slot_free = ~slot_v_q | gpr_ready;
    grant1    = rst & slot_free & win1;
    grant0    = rst & slot_free & req0_valid & ~win1;
    xfer      = grant0 | grant1;
    xfer_rd   = grant1 ? req1_rd   : req0_rd;
    xfer_data = grant1 ? req1_data : req0_data;

    slot_v_d    = slot_v_q & ~gpr_ready;
    slot_rd_d   = slot_rd_q;
    slot_data_d = slot_data_q;
    // writes to x0 are consumed but never occupy the slot
    if (xfer && (xfer_rd != '0)) begin
      slot_v_d    = 1'b1;
      slot_rd_d   = xfer_rd;
      slot_data_d = xfer_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v_q    <= 1'b0;
      slot_rd_q   <= '0;
      slot_data_q <= '0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_rd_q   <= slot_rd_d;
      slot_data_q <= slot_data_d;
    end
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    gpr_wen    = slot_v_q;
    gpr_waddr  = slot_rd_q;
    gpr_wdata  = slot_data_q;
    busy       = slot_v_q | req0_valid | req1_valid;
  end

endmodule

// File: tb/tb_ysyx_25060170_wb_arb.sv
// Self-checking bench for ysyx_25060170_wb_arb: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the slot and tie-break rule.
module tb_ysyx_25060170_wb_arb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0, gpr_ready = 1'b0;
  logic [AW-1:0] req0_rd = '0, req1_rd = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, gpr_wen, busy;
  logic [AW-1:0] gpr_waddr;
  logic [DW-1:0] gpr_wdata;

  ysyx_25060170_wb_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .gpr_ready(gpr_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what sits in the output slot and who wins a tie next
  typedef struct {
    bit          v;
    bit [AW-1:0] rd;
    bit [DW-1:0] data;
  } slot_t;

  slot_t       m_slot = '{0, 0, 0};
`ifdef YSYX_25060170_WB_ARB_FIXED_PRIO_EN
  localparam int PREF_RESET = 1;
`else
  localparam int PREF_RESET = 0;
`endif
  int          pref = PREF_RESET;
  int          m_win = -1;
  int          last_win = -1;
  bit [AW-1:0] m_rd;
  bit [DW-1:0] m_data;
  bit          m_gready;
  bit          check_en = 0;

  always @(negedge rst) begin
    m_slot = '{0, 0, 0};
    pref   = PREF_RESET;
    m_win  = -1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      m_win = -1;
      if (rst) begin
        if (!m_slot.v || gpr_ready) begin
          if (req0_valid && req1_valid) m_win = pref;
          else if (req0_valid)          m_win = 0;
          else if (req1_valid)          m_win = 1;
        end
      end
      m_rd     = (m_win == 1) ? req1_rd : req0_rd;
      m_data   = (m_win == 1) ? req1_data : req0_data;
      m_gready = gpr_ready;
      chk("req0_ready", 64'(req0_ready), 64'(m_win == 0));
      chk("req1_ready", 64'(req1_ready), 64'(m_win == 1));
      chk("gpr_wen",    64'(gpr_wen),    64'(m_slot.v));
      chk("gpr_waddr",  64'(gpr_waddr),  64'(m_slot.rd));
      chk("gpr_wdata",  64'(gpr_wdata),  64'(m_slot.data));
      chk("busy",       64'(busy),       64'(m_slot.v || req0_valid || req1_valid));
    end
  end

  always @(posedge clk) begin
    if (check_en && rst) begin
      last_win = m_win;
      if (m_win >= 0) begin
        if (m_rd != 0) m_slot = '{1, m_rd, m_data};
        else           m_slot.v = m_slot.v && !m_gready;
`ifndef YSYX_25060170_WB_ARB_FIXED_PRIO_EN
        pref = 1 - m_win;
`endif
      end else if (m_gready) begin
        m_slot.v = 0;
      end
    end else begin
      last_win = -1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  initial begin
    bit exp0;
    #1 rst = 0;
    check_en = 1;
    repeat (2) step();
    chk("reset_wen", 64'(gpr_wen), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1;

    // single requester
    req0_valid = 1; req0_rd = 5; req0_data = 32'h1234_5678; gpr_ready = 1;
    #1 chk("single_ready", 64'(req0_ready), 64'd1);
    step(); idle();
    #1 chk("single_wen", 64'(gpr_wen), 64'd1);
    chk("single_waddr", 64'(gpr_waddr), 64'd5);
    chk("single_wdata", 64'(gpr_wdata), 64'h1234_5678);
    step();
    #1 chk("single_drain", 64'(gpr_wen), 64'd0);

    // contention from a fresh reset
    rst = 0; step(); rst = 1;
    req0_valid = 1; req0_rd = 1; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 2; req1_data = 32'h22;
    gpr_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef YSYX_25060170_WB_ARB_FIXED_PRIO_EN
      exp0 = 0;
`else
      exp0 = (i % 2 == 0);
`endif
      #1 chk("rr_ready0", 64'(req0_ready), 64'(exp0));
      chk("rr_ready1", 64'(req1_ready), 64'(!exp0));
      step();
      #1 chk("rr_waddr", 64'(gpr_waddr), exp0 ? 64'd1 : 64'd2);
      chk("rr_wen", 64'(gpr_wen), 64'd1);
    end

    // backpressure
    req1_valid = 0; req0_rd = 7; req0_data = 32'hDEAD;
    #1 chk("bp_load", 64'(req0_ready), 64'd1);
    step();
    req0_rd = 8; req0_data = 32'h88; req1_valid = 1; req1_rd = 9; req1_data = 32'h99; gpr_ready = 0;
    repeat (3) begin
      #1 chk("bp_ready0", 64'(req0_ready), 64'd0);
      chk("bp_ready1", 64'(req1_ready), 64'd0);
      chk("bp_waddr", 64'(gpr_waddr), 64'd7);
      chk("bp_wdata", 64'(gpr_wdata), 64'hDEAD);
      step();
    end
    gpr_ready = 1;
    #1 chk("bp_release1", 64'(req1_ready), 64'd1);
    chk("bp_release0", 64'(req0_ready), 64'd0);
    step(); idle();
    #1 chk("bp_refill_addr", 64'(gpr_waddr), 64'd9);
    chk("bp_refill_data", 64'(gpr_wdata), 64'h99);

    // x0 discard, then verify tie-break moved to req1
    step();
    req0_valid = 1; req0_rd = 0; req0_data = 32'hFFFF_FFFF;
    #1 chk("x0_ready", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 0;
    #1 chk("x0_wen", 64'(gpr_wen), 64'd0);
    req0_valid = 1; req0_rd = 1; req1_valid = 1; req1_rd = 2;
    #1 chk("x0_prio1", 64'(req1_ready), 64'd1);
    chk("x0_prio0", 64'(req0_ready), 64'd0);
    step(); idle();

    // asynchronous reset with a stalled slot
    step();
    req0_valid = 1; req0_rd = 3; req0_data = 32'hAA; gpr_ready = 0;
    #1 chk("rst_load", 64'(req0_ready), 64'd1);
    step(); req0_valid = 0;
    #1 chk("rst_pre_wen", 64'(gpr_wen), 64'd1);
    chk("rst_pre_waddr", 64'(gpr_waddr), 64'd3);
    rst = 0;
    req1_valid = 1; req1_rd = 4; req1_data = 32'h44;
    #1 chk("rst_wen", 64'(gpr_wen), 64'd0);
    chk("rst_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst_wdata", 64'(gpr_wdata), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    step(); rst = 1;
    #1 chk("rst_first_grant", 64'(req1_ready), 64'd1);
    step(); req1_valid = 0;
    #1 chk("rst_first_waddr", 64'(gpr_waddr), 64'd4);
    chk("rst_first_wen", 64'(gpr_wen), 64'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst == 0) rst = 1;
      if (!(req0_valid && last_win != 0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : AW'($urandom);
        req0_data  = $urandom;
      end
      if (!(req1_valid && last_win != 1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : AW'($urandom);
        req1_data  = $urandom;
      end
      gpr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 0;
        #1 chk("rand_rst_wen", 64'(gpr_wen), 64'd0);
      end
    end

    step();
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_25060170_wb_arb.md
# ysyx_25060170_wb_arb

Writeback arbiter for the single GPR write port. It accepts results from two requesters, EXU (req0) and LSU (req1), each with a valid/ready handshake. It picks one per cycle by round-robin and holds the winner in a one-entry output register that drives the GPR `wen/waddr/wdata` inputs. It sits between the execute/memory stages and `ysyx_25060170_GPR`, and absorbs backpressure from the writeback stage's `ready` chain.

## Interface
- `DW`, 32, data width of a writeback result
- `AW`, 5, register-index width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req0_valid`  in  1  EXU result valid
- `req0_ready`  out  1  EXU result accepted this cycle
- `req0_rd`  in  AW  EXU destination register
- `req0_data`  in  DW  EXU result
- `req1_valid`  in  1  LSU result valid
- `req1_ready`  out  1  LSU result accepted this cycle
- `req1_rd`  in  AW  LSU destination register
- `req1_data`  in  DW  LSU result
- `gpr_wen`  out  1  registered write enable to GPR (output slot valid)
- `gpr_waddr`  out  AW  registered write address
- `gpr_wdata`  out  DW  registered write data
- `gpr_ready`  in  1  downstream (GPR `ready_o`) consumes slot this cycle
- `busy`  out  1  slot occupied or any request pending

## Operation
- State:
  - `slot_v`, `slot_rd`, `slot_data`: output slot.
  - `prio`: 1 bit, 0 means req0 preferred.
- `slot_free` = `!slot_v | gpr_ready` (slot empty, or draining this cycle).
- Grant:
  - Only one requester valid → that one, if `slot_free`.
  - Both valid → requester `prio` wins, if `slot_free`.
  - `reqK_ready` = `grantK`. It is combinational from `valid`, `prio`, `slot_free`. It does not depend on `reqK_rd`.
  - Both readies are forced 0 while `rst` is low.
- Handshake: a transfer happens when `reqK_valid & reqK_ready` at the rising edge.
- On transfer with `rd != 0`:
  - Slot loads `rd` and `data`; `slot_v` is set to 1.
  - `prio` is set to `~K`.
- On transfer with `rd == 0`:
  - Result is consumed and discarded.
  - `slot_v` is set to `slot_v & !gpr_ready`; slot contents are unchanged.
  - `prio` still toggles to `~K`.
- No transfer and `gpr_ready & slot_v` → `slot_v` is set to 0.
- Drain and refill in the same cycle is allowed, giving full throughput of one write per cycle.
- `gpr_wen` = `slot_v`; `gpr_waddr` = `slot_rd`; `gpr_wdata` = `slot_data`.
- While `gpr_wen` is high and `gpr_ready` is low, `gpr_waddr` and `gpr_wdata` must stay stable.
- `busy` = `slot_v | req0_valid | req1_valid`.
- Requesters must hold `rd` and `data` stable while `valid` is high and `ready` is low. The arbiter does not check this.

## Timing
- Latency: request accepted at edge N → `gpr_wen` high from edge N through the cycle after it. The GPR register updates at edge N+1 when `gpr_ready` is 1.
- Throughput: 1 accepted request per cycle while `gpr_ready` = 1.
- Reset (`rst` low, asynchronous):
  - Takes effect immediately, including mid-transfer.
  - `slot_v` = 0 → `gpr_wen` = 0.
  - `gpr_waddr` = 0, `gpr_wdata` = 0, `prio` = 0.
  - `req0_ready` = `req1_ready` = 0.
- A pending slot is lost on reset and is not replayed.
- First cycle after reset release: slot is empty, so a valid request is granted immediately.
- Stall: `slot_v` = 1 and `gpr_ready` = 0 → both readies are 0, and `prio` does not change.

## Configuration
- `YSYX_25060170_WB_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. req1 (LSU) always wins when both are valid. The `prio` register is removed.
  - Undefined (default): round-robin as described above.
- Handshake, slot and timing rules are identical in both builds.

## Test plan
- **Reset mid-operation.** Load slot with rd=3, data=0xAA, hold `gpr_ready`=0, then pull `rst` low between edges → `gpr_wen`=0, `gpr_waddr`=0, `gpr_wdata`=0 immediately. After release, req1 rd=4 is accepted on the first edge.
- **Single requester.** req0 rd=5, data=0x12345678, `gpr_ready`=1 → `req0_ready`=1. Next cycle `gpr_wen`=1, `gpr_waddr`=5, `gpr_wdata`=0x12345678. One cycle later `gpr_wen`=0.
- **Round-robin contention.** Both valid for 4 cycles with distinct rd (req0 rd=1, req1 rd=2), `gpr_ready`=1 → grant order req0, req1, req0, req1. `gpr_waddr` sequence is 1, 2, 1, 2 with no bubbles.
- **Backpressure.** Slot holds rd=7, data=0xDEAD, `gpr_ready`=0 for 3 cycles with both requesters valid → both readies stay 0 and outputs are stable. Raise `gpr_ready` → slot drains and the preferred requester is loaded in the same edge.
- **x0 discard.** req0 rd=0, data=0xFFFF_FFFF → `req0_ready`=1, `gpr_wen` stays 0, `prio` becomes 1.
- **Fixed-priority build.** Macro defined, both valid for 3 cycles → req1 is granted every cycle and `req0_ready` stays 0.
